us_burst_scheduler: RTL and testbench

Time-triggered sequencer for the ultrasonic transmitter, sitting between the free-running RTC counter and the US drive enable. Software pushes absolute start times over the Avalon slave port into a small FIFO. The block compares the head entry against the RTC time and asserts `us_enable` for a programmed number of clocks when that time is reached. It records the actual fire time, discards entries that are too late, and counts them.

---
 rtl/us_burst_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_us_burst_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_burst_scheduler.sv
// us_burst_scheduler: time-triggered ultrasonic burst sequencer.
// Software queues absolute RTC start times; each due head entry fires one us_enable burst.
module us_burst_scheduler #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          BURST_W        = 16,
    parameter logic [31:0] LATE_LIMIT_RST = 32'd500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rtc_time,
    input  logic [15:0] avalon_slave_address,
    input  logic        avalon_slave_write,
    input  logic [31:0] avalon_slave_writedata,
    input  logic        avalon_slave_read,
    output logic [31:0] avalon_slave_readdata,
    output logic        avalon_slave_waitrequest,
    output logic        us_enable,
    output logic        fire_pulse,
    output logic        fifo_empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               enable_q, enable_d;
    logic               overflow_q, overflow_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [31:0]        late_limit_q, late_limit_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;
    logic [31:0]        last_fired_q, last_fired_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               us_enable_q, us_enable_d;
    logic               fire_pulse_q, fire_pulse_d;
    logic               wait_q, wait_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [31:0]        mem_q [FIFO_DEPTH];

    logic [7:0]  addr_sel;
    logic        wr_acc, wr_ctrl, flush, push_req, push_ok, en_next;
    logic        empty, full, due, late, pop, fire_start, miss, rd_load;
    logic [31:0] head, diff, rd_mux, cnt_ext;
    logic [1:0]  state_bits;
    logic        unused_bits;

    assign addr_sel                 = avalon_slave_address[15:8];
    assign avalon_slave_waitrequest = wait_q & avalon_slave_read;
    assign wr_acc   = avalon_slave_write & ~avalon_slave_waitrequest;
    assign wr_ctrl  = wr_acc && (addr_sel == 8'h00);
    assign flush    = wr_ctrl && avalon_slave_writedata[1];
    assign push_req = wr_acc && (addr_sel == 8'h01);
    assign en_next  = wr_ctrl ? avalon_slave_writedata[0] : enable_q;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];
    // Modular difference: bit 31 clear means the head time has been reached, across RTC wrap.
    assign diff  = rtc_time - head;
    assign due   = ~diff[31];
    assign late  = diff > late_limit_q;

    // The head is examined while waiting, and on the last cycle of a burst so bursts chain without a gap.
    assign pop        = en_next && !flush && !empty && due &&
                        ((state_q != FIRE) || (burst_cnt_q == BURST_W'(1)));
    assign fire_start = pop && !late;
    assign miss       = pop && late;
    assign push_ok    = push_req && !flush && (!full || pop);
    assign rd_load    = avalon_slave_read & wait_q;

    assign cnt_ext     = 32'(count_q);
    assign state_bits  = state_q;
    assign unused_bits = ^{avalon_slave_address[7:0], cnt_ext[31:4]};

    always_comb begin
        rd_mux = 32'hDEADBEEF;
        case (addr_sel)
            8'h00: rd_mux = {23'b0, overflow_q, cnt_ext[3:0], state_bits, enable_q, 1'b0};
            8'h01: rd_mux = last_fired_q;
            8'h02: rd_mux = 32'(burst_len_q);
            8'h03: rd_mux = {16'b0, miss_cnt_q};
            8'h04: rd_mux = late_limit_q;
            default: rd_mux = 32'hDEADBEEF;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d      = state_q;
        enable_d     = en_next;
        overflow_d   = overflow_q;
        burst_len_d  = burst_len_q;
        burst_cnt_d  = burst_cnt_q;
        late_limit_d = late_limit_q;
        miss_cnt_d   = miss_cnt_q;
        last_fired_d = last_fired_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        us_enable_d  = 1'b0;
        fire_pulse_d = 1'b0;
        wait_d       = ~rd_load;
        readdata_d   = rd_load ? rd_mux : readdata_q;

        if (wr_ctrl && avalon_slave_writedata[2]) overflow_d = 1'b0;
        if (push_req && !flush && full && !pop)   overflow_d = 1'b1;
        if (wr_acc && (addr_sel == 8'h02)) burst_len_d  = avalon_slave_writedata[BURST_W-1:0];
        if (wr_acc && (addr_sel == 8'h04)) late_limit_d = avalon_slave_writedata;
        if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
        if (wr_acc && (addr_sel == 8'h03)) miss_cnt_d = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end

        if (!en_next || flush) begin
            state_d = IDLE;
        end else if (fire_start) begin
            state_d      = FIRE;
            burst_cnt_d  = (burst_len_q == '0) ? BURST_W'(1) : burst_len_q;
            us_enable_d  = 1'b1;
            fire_pulse_d = 1'b1;
            last_fired_d = rtc_time;
        end else if ((state_q == FIRE) && (burst_cnt_q != BURST_W'(1))) begin
            burst_cnt_d = burst_cnt_q - BURST_W'(1);
            us_enable_d = 1'b1;
        end else begin
            state_d = (count_d != '0) ? ARMED : IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            burst_len_q  <= BURST_W'(1);
            burst_cnt_q  <= '0;
            late_limit_q <= LATE_LIMIT_RST;
            miss_cnt_q   <= '0;
            last_fired_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            us_enable_q  <= 1'b0;
            fire_pulse_q <= 1'b0;
            wait_q       <= 1'b1;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            overflow_q   <= overflow_d;
            burst_len_q  <= burst_len_d;
            burst_cnt_q  <= burst_cnt_d;
            late_limit_q <= late_limit_d;
            miss_cnt_q   <= miss_cnt_d;
            last_fired_q <= last_fired_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            us_enable_q  <= us_enable_d;
            fire_pulse_q <= fire_pulse_d;
            wait_q       <= wait_d;
            readdata_q   <= readdata_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= avalon_slave_writedata;
    end

    assign us_enable             = us_enable_q;
    assign fire_pulse            = fire_pulse_q;
    assign fifo_empty            = empty;
    assign avalon_slave_readdata = readdata_q;

endmodule

// File: tb/tb_us_burst_scheduler.sv
// Bench for us_burst_scheduler: expected bursts are queued when start times are pushed
// and compared by a monitor when fire_pulse/us_enable appear; registers read over Avalon.
module tb_us_burst_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rtc_time = '0;
    logic [15:0] avalon_slave_address = '0;
    logic        avalon_slave_write = 1'b0;
    logic [31:0] avalon_slave_writedata = '0;
    logic        avalon_slave_read = 1'b0;
    logic [31:0] avalon_slave_readdata;
    logic        avalon_slave_waitrequest;
    logic        us_enable;
    logic        fire_pulse;
    logic        fifo_empty;

    us_burst_scheduler #(
        .FIFO_DEPTH(4),
        .BURST_W(16),
        .LATE_LIMIT_RST(32'd500)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rtc_time(rtc_time),
        .avalon_slave_address(avalon_slave_address),
        .avalon_slave_write(avalon_slave_write),
        .avalon_slave_writedata(avalon_slave_writedata),
        .avalon_slave_read(avalon_slave_read),
        .avalon_slave_readdata(avalon_slave_readdata),
        .avalon_slave_waitrequest(avalon_slave_waitrequest),
        .us_enable(us_enable),
        .fire_pulse(fire_pulse),
        .fifo_empty(fifo_empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] t;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   run_len  = 0;
    int   cur_len  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    task automatic expect_burst(input logic [31:0] t, input int len);
        exp_t e;
        e.t   = t;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Monitor: sampled 1 time unit after each rising edge, when rtc_time still holds the value the DUT saw.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (fire_pulse) begin
            if (run_len != 0) check("burst_len", 32'(run_len), 32'(cur_len));
            check("pulse_with_enable", {31'b0, us_enable}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_fire", {31'b0, fire_pulse}, 32'd0);
                cur_len = 0;
            end else begin
                e = exp_q.pop_front();
                check("fire_time", rtc_time, e.t);
                cur_len = e.len;
            end
            run_len = 1;
        end else if (us_enable) begin
            if (run_len == 0) check("enable_without_pulse", {31'b0, us_enable}, 32'd0);
            else run_len++;
        end else if (run_len != 0) begin
            check("burst_len", 32'(run_len), 32'(cur_len));
            run_len = 0;
        end
    end

    task automatic tick();
        @(negedge clock);
        rtc_time = rtc_time + 32'd1;
    endtask

    task automatic avm_write(input logic [7:0] sel, input logic [31:0] data);
        avalon_slave_address   = {sel, 8'h00};
        avalon_slave_writedata = data;
        avalon_slave_write     = 1'b1;
        tick();
        avalon_slave_write     = 1'b0;
    endtask

    task automatic avm_read(input logic [7:0] sel, output logic [31:0] data);
        int waits;
        avalon_slave_address = {sel, 8'h00};
        avalon_slave_read    = 1'b1;
        #1;
        waits = 0;
        while (avalon_slave_waitrequest && waits < 8) begin
            tick();
            waits++;
        end
        check("read_wait_states", 32'(waits), 32'd1);
        data = avalon_slave_readdata;
        tick();
        avalon_slave_read = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] sel, input logic [31:0] want);
        logic [31:0] d;
        avm_read(sel, d);
        check(tag, d, want);
    endtask

    task automatic wait_drain(output int hi);
        int n;
        n  = 0;
        hi = 0;
        while ((exp_q.size() != 0 || run_len != 0) && n < 3000) begin
            tick();
            n++;
            if (us_enable) hi++;
        end
        check("drain_done", 32'(exp_q.size() + run_len), 32'd0);
    endtask

    task automatic wait_enable_high(input string tag);
        int n;
        n = 0;
        while (!us_enable && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'b0, us_enable}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        int hi;
        #1 reset = 1'b1;
        #2;
        check("rst_us_enable", {31'b0, us_enable}, 32'd0);
        check("rst_fire_pulse", {31'b0, fire_pulse}, 32'd0);
        check("rst_fifo_empty", {31'b0, fifo_empty}, 32'd1);
        check("rst_readdata", avalon_slave_readdata, 32'd0);
        check("rst_waitreq_idle", {31'b0, avalon_slave_waitrequest}, 32'd0);
        avalon_slave_read = 1'b1;
        #1 check("rst_waitreq_read", {31'b0, avalon_slave_waitrequest}, 32'd1);
        avalon_slave_read = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tick();

        // Single burst of 10 at T=1000.
        avm_write(8'h00, 32'h1);
        avm_write(8'h02, 32'd10);
        rtc_time = 32'd900;
        expect_burst(32'd1000, 10);
        avm_write(8'h01, 32'd1000);
        check("a_not_empty", {31'b0, fifo_empty}, 32'd0);
        wait_drain(hi);
        check("a_high_cycles", 32'(hi), 32'd10);
        read_chk("a_last_fired", 8'h01, 32'd1000);
        read_chk("a_ctrl", 8'h00, 32'h2);

        // Three chained bursts of 4 with no gap; the third is reached during the second.
        avm_write(8'h02, 32'd4);
        rtc_time = 32'd1990;
        expect_burst(32'd2000, 4);
        expect_burst(32'd2004, 4);
        expect_burst(32'd2008, 4);
        avm_write(8'h01, 32'd2000);
        avm_write(8'h01, 32'd2000);
        avm_write(8'h01, 32'd2006);
        wait_drain(hi);
        check("b_high_cycles", 32'(hi), 32'd12);
        read_chk("b_last_fired", 8'h01, 32'd2008);
        read_chk("b_miss_cnt", 8'h03, 32'd0);

        // Start time just past the RTC wrap must wait for the wrap.
        rtc_time = 32'hFFFF_FFF0;
        expect_burst(32'd5, 4);
        avm_write(8'h01, 32'd5);
        wait_drain(hi);
        check("c_high_cycles", 32'(hi), 32'd4);
        read_chk("c_last_fired", 8'h01, 32'd5);

        // Late limit: within limit fires, beyond limit is discarded and counted.
        avm_write(8'h04, 32'd100);
        rtc_time = 32'd4999;
        expect_burst(32'd5000, 4);
        avm_write(8'h01, 32'd4950);
        wait_drain(hi);
        read_chk("d_last_fired", 8'h01, 32'd5000);
        rtc_time = 32'd4999;
        avm_write(8'h01, 32'd4800);
        tick();
        tick();
        read_chk("d_miss_1", 8'h03, 32'd1);
        check("d_empty_after_miss", {31'b0, fifo_empty}, 32'd1);
        rtc_time = 32'd4999;
        expect_burst(32'd5000, 4);
        avm_write(8'h01, 32'd4900);
        wait_drain(hi);
        read_chk("d_miss_at_limit", 8'h03, 32'd1);
        rtc_time = 32'd4999;
        avm_write(8'h01, 32'd4899);
        tick();
        tick();
        read_chk("d_miss_2", 8'h03, 32'd2);

        // Overflow with the scheduler disabled, then clear and flush.
        avm_write(8'h00, 32'h0);
        for (int i = 0; i < 5; i++) avm_write(8'h01, 32'h1000_0000 + 32'(i));
        read_chk("e_ctrl_full", 8'h00, 32'h140);
        check("e_not_empty", {31'b0, fifo_empty}, 32'd0);
        avm_write(8'h00, 32'h4);
        read_chk("e_ctrl_ovf_clr", 8'h00, 32'h040);
        avm_write(8'h00, 32'h2);
        check("e_flush_empty", {31'b0, fifo_empty}, 32'd1);
        read_chk("e_ctrl_flushed", 8'h00, 32'h0);

        // Clearing enable mid-burst drops us_enable at the write edge.
        avm_write(8'h02, 32'd10);
        avm_write(8'h00, 32'h1);
        rtc_time = 32'd5998;
        expect_burst(32'd6000, 3);
        avm_write(8'h01, 32'd6000);
        wait_enable_high("f_fire_seen");
        tick();
        tick();
        avm_write(8'h00, 32'h0);
        check("f_abort_low", {31'b0, us_enable}, 32'd0);
        wait_drain(hi);

        // Reset mid-burst: us_enable drops at once and the queue clears.
        avm_write(8'h00, 32'h1);
        rtc_time = 32'd6997;
        expect_burst(32'd7000, 2);
        avm_write(8'h01, 32'd7000);
        avm_write(8'h01, 32'd9000);
        wait_enable_high("g_fire_seen");
        tick();
        reset = 1'b1;
        #1;
        check("g_reset_low", {31'b0, us_enable}, 32'd0);
        check("g_reset_empty", {31'b0, fifo_empty}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        read_chk("g_burst_len_rst", 8'h02, 32'd1);
        read_chk("g_late_limit_rst", 8'h04, 32'd500);
        read_chk("g_miss_rst", 8'h03, 32'd0);
        read_chk("g_last_fired_rst", 8'h01, 32'd0);
        read_chk("g_ctrl_rst", 8'h00, 32'h0);

        // A programmed length of 0 behaves as 1.
        avm_write(8'h02, 32'd0);
        avm_write(8'h00, 32'h1);
        rtc_time = 32'd7998;
        expect_burst(32'd8000, 1);
        avm_write(8'h01, 32'd8000);
        wait_drain(hi);
        check("h_len0_high", 32'(hi), 32'd1);

        // Unmapped address.
        read_chk("h_unmapped", 8'h07, 32'hDEADBEEF);

        tick();
        tick();
        check("exp_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
